// File: rtl/voq_pri_req_gen.sv
// Per-VOQ occupancy/age tracking for an NxN switch, presenting one registered priority snapshot per scheduling round.
// Build option: define VOQ_AGING_EN to add saturating per-VOQ age counters to the priority.
module voq_pri_req_gen #(
   parameter int N      = 4,
   parameter int P      = 16,
   parameter int QDEPTH = 15
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [N-1:0]                       arr_valid,
   input  logic [N-1:0][$clog2(N)-1:0]        arr_dest,
   input  logic [N-1:0][N-1:0]                decision,
   input  logic                               decision_ready,
   output logic [0:N-1][0:N-1][$clog2(P)-1:0] pri_req_out,
   output logic                               start,
   output logic [N-1:0]                       drop,
   output logic                               grant_err
);

   localparam int PW = $clog2(P);
   localparam int CW = $clog2(QDEPTH + 1);
   localparam int DW = $clog2(N);
   localparam int SW = ((CW > PW) ? CW : PW) + 1;

   typedef enum logic [1:0] {IDLE, SNAP, WAIT, APPLY} state_t;

   state_t                      state;
   logic [N-1:0][N-1:0][CW-1:0] cnt, cnt_nxt;
`ifdef VOQ_AGING_EN
   logic [N-1:0][N-1:0][PW-1:0] age, age_nxt;
`endif
   logic [N-1:0][N-1:0]         dec_q, hit, granted, retire;
   logic [0:N-1][0:N-1][PW-1:0] pri_now;
   logic [N-1:0]                drop_nxt;
   logic                        gerr_nxt, busy_now, busy_nxt;
   logic [SW-1:0]               sum;

   always_comb begin
      pri_now  = '0;
      busy_now = 1'b0;
      sum      = '0;
      for (int unsigned i = 0; i < N; i++) begin
         for (int unsigned j = 0; j < N; j++) begin
`ifdef VOQ_AGING_EN
            sum = SW'(cnt[i][j]) + SW'(age[i][j]);
`else
            sum = SW'(cnt[i][j]);
`endif
            if (cnt[i][j] != '0) begin
               busy_now      = 1'b1;
               pri_now[i][j] = (sum > SW'(P - 1)) ? PW'(P - 1) : sum[PW-1:0];
            end
         end
      end
   end

   always_comb begin
      cnt_nxt  = cnt;
      drop_nxt = '0;
      gerr_nxt = 1'b0;
      busy_nxt = 1'b0;
      hit      = '0;
      granted  = '0;
      retire   = '0;
`ifdef VOQ_AGING_EN
      age_nxt  = age;
`endif
      for (int unsigned i = 0; i < N; i++) begin
         for (int unsigned j = 0; j < N; j++) begin
            hit[i][j]     = arr_valid[i] && (arr_dest[i] == DW'(j));
            granted[i][j] = (state == APPLY) && dec_q[i][j];
            retire[i][j]  = granted[i][j] && (pri_req_out[i][j] != '0);
            if (granted[i][j] && (pri_req_out[i][j] == '0))
               gerr_nxt = 1'b1;
            // an arrival and a retire on the same VOQ cancel, so a full queue takes no drop
            if (hit[i][j] && !retire[i][j]) begin
               if (cnt[i][j] == CW'(QDEPTH))
                  drop_nxt[i] = 1'b1;
               else
                  cnt_nxt[i][j] = cnt[i][j] + CW'(1);
            end else if (retire[i][j] && !hit[i][j]) begin
               cnt_nxt[i][j] = cnt[i][j] - CW'(1);
            end
`ifdef VOQ_AGING_EN
            if (retire[i][j] || (cnt_nxt[i][j] == '0))
               age_nxt[i][j] = '0;
            else if ((state == APPLY) && !dec_q[i][j] && (cnt[i][j] != '0) &&
                     (age[i][j] != PW'(P - 1)))
               age_nxt[i][j] = age[i][j] + PW'(1);
`endif
            if (cnt_nxt[i][j] != '0)
               busy_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
`ifdef VOQ_AGING_EN
         age         <= '0;
`endif
         dec_q       <= '0;
         pri_req_out <= '0;
         start       <= 1'b0;
         drop        <= '0;
         grant_err   <= 1'b0;
      end else begin
         cnt       <= cnt_nxt;
`ifdef VOQ_AGING_EN
         age       <= age_nxt;
`endif
         drop      <= drop_nxt;
         grant_err <= gerr_nxt;
         start     <= 1'b0;
         case (state)
            IDLE: begin
               if (busy_now)
                  state <= SNAP;
            end
            SNAP: begin
               pri_req_out <= pri_now;
               start       <= 1'b1;
               state       <= WAIT;
            end
            WAIT: begin
               if (decision_ready) begin
                  dec_q <= decision;
                  state <= APPLY;
               end
            end
            APPLY: begin
               if (busy_nxt) begin
                  state <= SNAP;
               end else begin
                  state       <= IDLE;
                  pri_req_out <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_voq_pri_req_gen.sv
// Directed bench for voq_pri_req_gen: a round-level reference model checked every cycle, plus literal expectations.
module tb_voq_pri_req_gen;

   localparam int N  = 4;
   localparam int P  = 16;
   localparam int QD = 15;
   localparam int PW = 4;
`ifdef VOQ_AGING_EN
   localparam bit AGING = 1'b1;
`else
   localparam bit AGING = 1'b0;
`endif

   logic                        clk   = 1'b0;
   logic                        reset = 1'b1;
   logic [N-1:0]                arr_valid = '0;
   logic [N-1:0][1:0]           arr_dest  = '0;
   logic [N-1:0][N-1:0]         decision  = '0;
   logic                        decision_ready = 1'b0;
   logic [0:N-1][0:N-1][PW-1:0] pri_req_out;
   logic                        start;
   logic [N-1:0]                drop;
   logic                        grant_err;

   voq_pri_req_gen #(.N(N), .P(P), .QDEPTH(QD)) dut (
      .clk            (clk),
      .reset          (reset),
      .arr_valid      (arr_valid),
      .arr_dest       (arr_dest),
      .decision       (decision),
      .decision_ready (decision_ready),
      .pri_req_out    (pri_req_out),
      .start          (start),
      .drop           (drop),
      .grant_err      (grant_err)
   );

   always #5 clk = ~clk;

   // reference model: queue contents, ages and the round phase
   typedef enum {M_IDLE, M_SNAP, M_WAIT, M_APPLY} phase_t;
   phase_t                      ph;
   int                          m_cnt [N][N];
   int                          m_age [N][N];
   int                          n_cnt [N][N];
   int                          n_age [N][N];
   logic [N-1:0][N-1:0]         m_dec;
   logic [0:N-1][0:N-1][PW-1:0] e_pri;
   logic                        e_start, e_gerr, n_gerr;
   logic [N-1:0]                e_drop, n_drop;
   bit                          arr, gr, ret, busy, left;
   int                          d;

   function automatic int prio(input int c, input int a);
      int s;
      if (c == 0) return 0;
      s = AGING ? c + a : c;
      return (s > P - 1) ? P - 1 : s;
   endfunction

   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            for (int i = 0; i < N; i++)
               for (int j = 0; j < N; j++) begin
                  m_cnt[i][j] = 0;
                  m_age[i][j] = 0;
               end
            ph = M_IDLE; m_dec = '0; e_pri = '0;
            e_start = 1'b0; e_drop = '0; e_gerr = 1'b0;
         end else begin
            n_drop = '0; n_gerr = 1'b0; busy = 0; left = 0;
            for (int i = 0; i < N; i++)
               for (int j = 0; j < N; j++) begin
                  arr = arr_valid[i] && (int'(arr_dest[i]) == j);
                  gr  = (ph == M_APPLY) && m_dec[i][j];
                  ret = gr && (e_pri[i][j] != 0);
                  d   = int'(arr) - int'(ret);
                  if (m_cnt[i][j] + d > QD) begin
                     n_drop[i]   = 1'b1;
                     n_cnt[i][j] = m_cnt[i][j];
                  end else begin
                     n_cnt[i][j] = m_cnt[i][j] + d;
                  end
                  n_age[i][j] = m_age[i][j];
                  if (ret) n_age[i][j] = 0;
                  else if (ph == M_APPLY && !gr && m_cnt[i][j] > 0)
                     n_age[i][j] = (m_age[i][j] + 1 > P - 1) ? P - 1 : m_age[i][j] + 1;
                  if (n_cnt[i][j] == 0) n_age[i][j] = 0;
                  if (gr && e_pri[i][j] == 0) n_gerr = 1'b1;
                  if (m_cnt[i][j] > 0) busy = 1;
                  if (n_cnt[i][j] > 0) left = 1;
               end
            e_start = 1'b0;
            case (ph)
               M_IDLE:  if (busy) ph = M_SNAP;
               M_SNAP: begin
                  for (int i = 0; i < N; i++)
                     for (int j = 0; j < N; j++)
                        e_pri[i][j] = 4'(prio(m_cnt[i][j], m_age[i][j]));
                  e_start = 1'b1;
                  ph = M_WAIT;
               end
               M_WAIT: if (decision_ready) begin m_dec = decision; ph = M_APPLY; end
               M_APPLY: begin
                  if (left) ph = M_SNAP;
                  else begin ph = M_IDLE; e_pri = '0; end
               end
            endcase
            m_cnt = n_cnt; m_age = n_age;
            e_drop = n_drop; e_gerr = n_gerr;
         end
      end
   end

   int total  = 0;
   int passed = 0;
   int starts = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   task automatic compare_all();
      check("cyc_pri",   64'(pri_req_out), 64'(e_pri));
      check("cyc_start", 64'(start),       64'(e_start));
      check("cyc_drop",  64'(drop),        64'(e_drop));
      check("cyc_gerr",  64'(grant_err),   64'(e_gerr));
      if (start) starts++;
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
         compare_all();
      end
   endtask

   task automatic arrive(input int i, input int dst);
      arr_valid[i] = 1'b1;
      arr_dest[i]  = 2'(dst);
      cyc(1);
      arr_valid    = '0;
   endtask

   task automatic decide(input logic [N-1:0][N-1:0] g);
      decision       = g;
      decision_ready = 1'b1;
      cyc(1);
      decision_ready = 1'b0;
      decision       = '0;
   endtask

   task automatic wait_start(input string name);
      int n = 0;
      while (!start && n < 20) begin
         cyc(1);
         n++;
      end
      if (!start) check({name, "_start_timeout"}, 64'(0), 64'(1));
   endtask

   initial begin
      logic [0:N-1][0:N-1][PW-1:0] lit;
      logic [N-1:0][N-1:0]         g;
      int                          s0;

      cyc(2);
      check("rst_pri",   64'(pri_req_out), 64'(0));
      check("rst_start", 64'(start),       64'(0));
      check("rst_drop",  64'(drop),        64'(0));
      check("rst_gerr",  64'(grant_err),   64'(0));
      reset = 1'b0;
      cyc(2);

      // single arrival: two-edge latency to start, one snapshot entry
      arrive(0, 2);
      check("t1_start_k", 64'(start), 64'(0));
      cyc(1); check("t1_start_k1", 64'(start), 64'(0));
      cyc(1); check("t1_start_k2", 64'(start), 64'(1));
      lit = '0; lit[0][2] = 4'd1;
      check("t1_pri", 64'(pri_req_out), 64'(lit));
      cyc(3);
      check("t1_hold", 64'(pri_req_out), 64'(lit));
      check("t1_one_start", 64'(starts), 64'(1));
      g = '0; g[0][2] = 1'b1;
      decide(g); cyc(1);
      check("t1_idle_pri", 64'(pri_req_out), 64'(0));

      // three cells on [1][3], one retired
      arrive(1, 3); arrive(1, 3); arrive(1, 3);
      wait_start("t2a");
      check("t2_first_pri", 64'(pri_req_out[1][3]), 64'(2));
      g = '0; g[1][3] = 1'b1;
      decide(g);
      wait_start("t2b");
      check("t2_after_grant", 64'(pri_req_out[1][3]), 64'(2));
      decide(g); wait_start("t2c"); decide(g); cyc(1);
      check("t2_drained", 64'(pri_req_out), 64'(0));

      // one cell on [2][0] left waiting for five rounds
      arrive(2, 0);
      wait_start("t3");
      for (int r = 1; r <= 6; r++) begin
         check("t3_age_pri", 64'(pri_req_out[2][0]), 64'(AGING ? r : 1));
         if (r < 6) begin
            decide('0);
            wait_start("t3r");
         end
      end
      g = '0; g[2][0] = 1'b1;
      decide(g); cyc(1);
      check("t3_idle_pri", 64'(pri_req_out), 64'(0));

      // grant to an empty VOQ
      arrive(1, 1);
      wait_start("t4");
      g = '0; g[0][0] = 1'b1;
      decide(g); cyc(1);
      check("t4_gerr_pulse", 64'(grant_err), 64'(1));
      cyc(1);
      check("t4_gerr_clear", 64'(grant_err), 64'(0));
      wait_start("t4b");
      check("t4_pri00", 64'(pri_req_out[0][0]), 64'(0));
      check("t4_pri11", 64'(pri_req_out[1][1]), 64'(AGING ? 2 : 1));
      g = '0; g[1][1] = 1'b1;
      decide(g); cyc(1);

      // fill [3][1], overflow, then arrival alongside a retire
      for (int k = 0; k < 15; k++) arrive(3, 1);
      arrive(3, 1);
      check("t5_drop", 64'(drop), 64'(4'b1000));
      cyc(1);
      check("t5_drop_clear", 64'(drop), 64'(0));
      decide('0);
      wait_start("t5a");
      check("t5_full_pri", 64'(pri_req_out[3][1]), 64'(15));
      g = '0; g[3][1] = 1'b1;
      decision = g; decision_ready = 1'b1;
      cyc(1);
      decision_ready = 1'b0; decision = '0;
      arr_valid[3] = 1'b1; arr_dest[3] = 2'd1;
      cyc(1);
      arr_valid = '0;
      check("t5_no_drop_on_retire", 64'(drop), 64'(0));
      wait_start("t5b");
      check("t5_still_full", 64'(pri_req_out[3][1]), 64'(15));
      arrive(3, 1);
      check("t5_drop_again", 64'(drop), 64'(4'b1000));

      // reset in WAIT with cells queued
      reset = 1'b1;
      #1;
      check("t6_pri",   64'(pri_req_out), 64'(0));
      check("t6_start", 64'(start),       64'(0));
      check("t6_drop",  64'(drop),        64'(0));
      check("t6_gerr",  64'(grant_err),   64'(0));
      cyc(2);
      reset = 1'b0;
      s0 = starts;
      decide('1);
      cyc(6);
      check("t6_no_start", 64'(starts), 64'(s0));
      check("t6_idle_pri", 64'(pri_req_out), 64'(0));
      check("t6_idle_gerr", 64'(grant_err), 64'(0));
      arrive(1, 0);
      cyc(2);
      check("t6_restart", 64'(start), 64'(1));
      check("t6_restart_pri", 64'(pri_req_out[1][0]), 64'(1));
      cyc(2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
